uart_tx_scheduler: RTL and testbench

//  Shares one MS_UART_TX-style transmitter (START/BUSY/DONE/DIN) between NUM_REQ byte requesters.
//  - Round-robin arbitration; each requester gets a valid/ready byte handshake.
//  - Winning byte is latched, then the TX START level is held until the core acknowledges with BUSY.
//  - Completion is the BUSY falling edge; watchdogs recover from a stuck core.

---
 rtl/uart_tx_scheduler_pkg.sv | 23 ++
 rtl/uart_tx_scheduler_rr_pick.sv | 43 ++++
 rtl/uart_tx_scheduler.sv | 150 +++++++++++++++
 tb/tb_uart_tx_scheduler.sv | 364 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_scheduler_pkg.sv
// ============================================================================
//  Module : uart_tx_scheduler_pkg
//  Brief  : Shared types and constants for the UART TX scheduler:
//           scheduler state encoding and the default watchdog limit.
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package uart_tx_scheduler_pkg;

  // Scheduler FSM states; encodings are fixed so debug probes read them directly.
  typedef enum logic [1:0] {
    SCH_IDLE   = 2'd0,
    SCH_LAUNCH = 2'd1,
    SCH_WAIT   = 2'd2
  } sch_state_t;

  // Default CLK cycles allowed in LAUNCH or WAIT_DONE before the byte is aborted.
  localparam int C_TO_CYC_DEF = 4096;

endpackage

`default_nettype wire

// File: rtl/uart_tx_scheduler_rr_pick.sv
// ============================================================================
//  Module : rr_pick
//  Brief  : Combinational round-robin picker. Returns the first set request
//           bit found searching upward from i_ptr, wrapping modulo NUM_REQ.
//  Rev    : 1.0  initial release
//
//  Ports
//    i_req   in   NUM_REQ   request vector
//    i_ptr   in   IDX_W     highest-priority index for this pick
//    o_any   out  1         at least one request is set
//    o_idx   out  IDX_W     index of the winning request (0 when o_any=0)
// ============================================================================
`default_nettype none

module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IDX_W-1:0]   i_ptr,
  output logic               o_any,
  output logic [IDX_W-1:0]   o_idx
);

  int w_pos;

  // Walk the rotated order from farthest to nearest so the last hit written
  // is the one closest to i_ptr.
  always_comb begin
    o_any = |i_req;
    o_idx = '0;
    w_pos = 0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      w_pos = (int'(i_ptr) + k) % NUM_REQ;
      if (i_req[w_pos]) begin
        o_idx = w_pos[IDX_W-1:0];
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/uart_tx_scheduler.sv
// ============================================================================
//  Module : uart_tx_scheduler
//  Brief  : Shares one START/BUSY style UART transmitter between NUM_REQ byte
//           requesters with round-robin arbitration, START/BUSY handshake,
//           BUSY-fall completion and a watchdog against a stuck core.
//  Rev    : 1.0  initial release
//
//  Ports
//    CLK            in   1                 system clock, posedge
//    RESETN         in   1                 synchronous reset, active-low
//    i_req_valid    in   NUM_REQ           requester i holds a byte
//    i_req_data     in   NUM_REQ*DATA_W    byte of requester i at [i*DATA_W +: DATA_W]
//    i_req_lock     in   NUM_REQ           keep priority on requester after its grant
//    o_req_ready    out  NUM_REQ           one-cycle one-hot accept pulse
//    o_tx_start     out  1                 START level to the transmitter
//    o_tx_data      out  DATA_W            latched byte to the transmitter
//    i_tx_busy      in   1                 transmitter BUSY
//    o_grant_id     out  clog2(NUM_REQ)    current/last granted requester
//    o_active       out  1                 byte in LAUNCH or WAIT_DONE
//    o_err_timeout  out  1                 one-cycle pulse on watchdog abort
// ============================================================================
`default_nettype none

module uart_tx_scheduler
  import uart_tx_scheduler_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 8,
  parameter int TO_W    = 16,
  parameter int TO_CYC  = C_TO_CYC_DEF
) (
  input  logic                      CLK,
  input  logic                      RESETN,
  input  logic [NUM_REQ-1:0]        i_req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] i_req_data,
  input  logic [NUM_REQ-1:0]        i_req_lock,
  output logic [NUM_REQ-1:0]        o_req_ready,
  output logic                      o_tx_start,
  output logic [DATA_W-1:0]         o_tx_data,
  input  logic                      i_tx_busy,
  output logic [$clog2(NUM_REQ)-1:0] o_grant_id,
  output logic                      o_active,
  output logic                      o_err_timeout
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam logic [TO_W-1:0] C_WD_LAST = TO_W'(TO_CYC - 1);

  sch_state_t          r_state;
  logic [IDX_W-1:0]    r_ptr;
  logic [TO_W-1:0]     r_wd;
  logic [NUM_REQ-1:0]  r_req_ready;
  logic                r_tx_start;
  logic [DATA_W-1:0]   r_tx_data;
  logic [IDX_W-1:0]    r_grant_id;
  logic                r_active;
  logic                r_err_timeout;

  logic                w_any;
  logic [IDX_W-1:0]    w_pick;
  logic [IDX_W-1:0]    w_next;
  logic [TO_W-1:0]     w_wd_inc;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_pick (
    .i_req (i_req_valid),
    .i_ptr (r_ptr),
    .o_any (w_any),
    .o_idx (w_pick)
  );

  assign w_next   = (w_pick == IDX_W'(NUM_REQ - 1)) ? '0 : w_pick + IDX_W'(1);
  // Saturating increment: the abort fires at C_WD_LAST, this only guards wrap.
  assign w_wd_inc = (r_wd == '1) ? r_wd : r_wd + TO_W'(1);

  always_ff @(posedge CLK) begin
    if (!RESETN) begin
      r_state       <= SCH_IDLE;
      r_ptr         <= '0;
      r_wd          <= '0;
      r_req_ready   <= '0;
      r_tx_start    <= 1'b0;
      r_tx_data     <= '0;
      r_grant_id    <= '0;
      r_active      <= 1'b0;
      r_err_timeout <= 1'b0;
    end else begin
      r_req_ready   <= '0;
      r_err_timeout <= 1'b0;
      case (r_state)
        SCH_IDLE: begin
          if (w_any) begin
            r_tx_data   <= i_req_data[w_pick*DATA_W +: DATA_W];
            r_grant_id  <= w_pick;
            r_req_ready <= {{(NUM_REQ-1){1'b0}}, 1'b1} << w_pick;
            r_tx_start  <= 1'b1;
            r_active    <= 1'b1;
            r_wd        <= '0;
            r_ptr       <= i_req_lock[w_pick] ? w_pick : w_next;
            r_state     <= SCH_LAUNCH;
          end
        end
        SCH_LAUNCH: begin
          // BUSY acknowledge is checked first so it wins over a same-cycle expiry.
          if (i_tx_busy) begin
            r_tx_start <= 1'b0;
            r_wd       <= '0;
            r_state    <= SCH_WAIT;
          end else if (r_wd == C_WD_LAST) begin
            r_tx_start    <= 1'b0;
            r_active      <= 1'b0;
            r_err_timeout <= 1'b1;
            r_state       <= SCH_IDLE;
          end else begin
            r_wd <= w_wd_inc;
          end
        end
        SCH_WAIT: begin
          if (!i_tx_busy) begin
            r_active <= 1'b0;
            r_state  <= SCH_IDLE;
          end else if (r_wd == C_WD_LAST) begin
            r_active      <= 1'b0;
            r_err_timeout <= 1'b1;
            r_state       <= SCH_IDLE;
          end else begin
            r_wd <= w_wd_inc;
          end
        end
        default: begin
          r_tx_start <= 1'b0;
          r_active   <= 1'b0;
          r_state    <= SCH_IDLE;
        end
      endcase
    end
  end

  assign o_req_ready   = r_req_ready;
  assign o_tx_start    = r_tx_start;
  assign o_tx_data     = r_tx_data;
  assign o_grant_id    = r_grant_id;
  assign o_active      = r_active;
  assign o_err_timeout = r_err_timeout;

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_scheduler.sv
// ============================================================================
//  Module : tb_uart_tx_scheduler
//  Brief  : Scoreboard bench for uart_tx_scheduler. Requesters and a UART TX
//           model are driven from the bench; expected grants come from a
//           round-robin reference model over the driven request vector.
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_uart_tx_scheduler;

  localparam int NUM_REQ = 4;
  localparam int DATA_W  = 8;
  localparam int TO_W    = 16;
  localparam int TO_CYC  = 64;

  logic                      CLK = 1'b0;
  logic                      RESETN = 1'b0;
  logic [NUM_REQ-1:0]        i_req_valid = '0;
  logic [NUM_REQ*DATA_W-1:0] i_req_data = '0;
  logic [NUM_REQ-1:0]        i_req_lock = '0;
  logic [NUM_REQ-1:0]        o_req_ready;
  logic                      o_tx_start;
  logic [DATA_W-1:0]         o_tx_data;
  logic                      i_tx_busy = 1'b0;
  logic [1:0]                o_grant_id;
  logic                      o_active;
  logic                      o_err_timeout;

  always #5 CLK = ~CLK;

  uart_tx_scheduler #(
    .NUM_REQ (NUM_REQ),
    .DATA_W  (DATA_W),
    .TO_W    (TO_W),
    .TO_CYC  (TO_CYC)
  ) dut (
    .CLK           (CLK),
    .RESETN        (RESETN),
    .i_req_valid   (i_req_valid),
    .i_req_data    (i_req_data),
    .i_req_lock    (i_req_lock),
    .o_req_ready   (o_req_ready),
    .o_tx_start    (o_tx_start),
    .o_tx_data     (o_tx_data),
    .i_tx_busy     (i_tx_busy),
    .o_grant_id    (o_grant_id),
    .o_active      (o_active),
    .o_err_timeout (o_err_timeout)
  );

  typedef struct {
    int         g;
    logic [7:0] d;
    bit         err;
    int         starts;
  } exp_t;

  typedef struct {
    int d;  // cycles START stays high before BUSY is seen; 0 = core never answers
    int l;  // cycles BUSY stays high
  } beh_t;

  exp_t exp_q[$];
  beh_t beh_q[$];
  int   total = 0;
  int   bad = 0;
  int   mptr = 0;
  bit   stop_run = 1'b0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, req);
    end
  endtask

  // Reference arbiter: next grant from the current request vector and pointer.
  task automatic push_exp(input int d, input int l);
    exp_t e;
    beh_t b;
    int   g;
    g = -1;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (g < 0 && i_req_valid[(mptr + k) % NUM_REQ]) g = (mptr + k) % NUM_REQ;
    end
    if (g >= 0) begin
      e.g      = g;
      e.d      = i_req_data[g*DATA_W +: DATA_W];
      e.err    = (d == 0) || (l > TO_CYC);
      e.starts = (d == 0) ? TO_CYC : d;
      b.d      = d;
      b.l      = l;
      exp_q.push_back(e);
      beh_q.push_back(b);
      mptr = i_req_lock[g] ? g : (g + 1) % NUM_REQ;
    end
  endtask

  task automatic wait_ready(output int idx);
    idx = 0;
    for (int n = 0; n < 400; n++) begin
      @(negedge CLK);
      if (o_req_ready != '0) begin
        for (int i = 0; i < NUM_REQ; i++) if (o_req_ready[i]) idx = i;
        return;
      end
    end
    total++;
    bad++;
    stop_run = 1'b1;
    $display("FAIL ready_timeout: got no req_ready within 400 cycles, want a grant");
  endtask

  task automatic wait_idle();
    for (int n = 0; n < 600; n++) begin
      @(negedge CLK);
      if (!o_active && !i_tx_busy) return;
    end
    total++;
    bad++;
    stop_run = 1'b1;
    $display("FAIL idle_timeout: active=%0b busy=%0b, want both 0", o_active, i_tx_busy);
  endtask

  task automatic add_random();
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!i_req_valid[i] && $urandom_range(0, 1) == 1) begin
        i_req_valid[i] = 1'b1;
        i_req_data[i*DATA_W +: DATA_W] = 8'($urandom);
      end
    end
  endtask

  task automatic push_random();
    if ($urandom_range(0, 7) == 0) push_exp(0, 0);
    else push_exp(int'($urandom_range(1, TO_CYC)), int'($urandom_range(1, 50)));
  endtask

  // UART TX model: answers each START with BUSY according to the queued behaviour.
  initial begin
    beh_t b;
    forever begin
      @(negedge CLK);
      if (RESETN && o_tx_start) begin
        if (beh_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_start: got tx_start with no grant pending, want none");
          b.d = 1;
          b.l = 1;
        end else begin
          b = beh_q.pop_front();
        end
        if (b.d == 0) begin
          for (int n = 0; n < 4 * TO_CYC && o_tx_start; n++) @(negedge CLK);
        end else begin
          repeat (b.d - 1) @(negedge CLK);
          i_tx_busy = 1'b1;
          repeat (b.l) @(negedge CLK);
          i_tx_busy = 1'b0;
        end
      end
    end
  end

  // Monitor: pops the scoreboard on each accept pulse and checks each byte's outcome.
  exp_t cur;
  bit   in_byte = 1'b0;
  bit   err_seen = 1'b0;
  bit   prev_active = 1'b0;
  int   starts = 0;

  always @(negedge CLK) begin
    if (!RESETN) begin
      in_byte     = 1'b0;
      prev_active = 1'b0;
    end else begin
      if (o_req_ready != '0) begin
        check("no_overlap", 32'(in_byte), 32'd0);
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_ready: got ready=%b, want no grant", o_req_ready);
        end else begin
          cur = exp_q.pop_front();
          check("ready_onehot", 32'(o_req_ready), 32'(1) << cur.g);
          check("grant_id", 32'(o_grant_id), 32'(cur.g));
          check("tx_data", 32'(o_tx_data), 32'(cur.d));
          check("start_on_grant", 32'(o_tx_start), 32'd1);
          check("active_on_grant", 32'(o_active), 32'd1);
          in_byte  = 1'b1;
          err_seen = 1'b0;
          starts   = 0;
        end
      end
      if (in_byte && o_tx_start) starts++;
      if (o_err_timeout) begin
        check("err_expected", 32'(in_byte && cur.err), 32'd1);
        check("err_grant_id", 32'(o_grant_id), 32'(cur.g));
        err_seen = 1'b1;
      end
      if (prev_active && !o_active && in_byte) begin
        check("start_cycles", 32'(starts), 32'(cur.starts));
        check("err_outcome", 32'(err_seen), 32'(cur.err));
        in_byte = 1'b0;
      end
      prev_active = o_active;
    end
  end

  initial begin
    #500000;
    total++;
    bad++;
    $display("FAIL global_timeout: simulation did not complete");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    int idx;
    int j;

    // Reset state
    repeat (3) @(negedge CLK);
    check("rst_ready", 32'(o_req_ready), 32'd0);
    check("rst_start", 32'(o_tx_start), 32'd0);
    check("rst_data", 32'(o_tx_data), 32'd0);
    check("rst_grant", 32'(o_grant_id), 32'd0);
    check("rst_active", 32'(o_active), 32'd0);
    check("rst_err", 32'(o_err_timeout), 32'd0);
    RESETN = 1'b1;
    repeat (3) @(negedge CLK);
    check("idle_no_ready", 32'(o_req_ready), 32'd0);

    // Single request, START held 20 cycles, BUSY 60 cycles
    i_req_data[7:0] = 8'hA5;
    i_req_valid = 4'b0001;
    push_exp(20, 60);
    wait_ready(idx);
    i_req_valid = '0;
    wait_idle();

    // All four requesting, no lock, each re-raised after its accept
    i_req_lock = '0;
    i_req_data = {8'h44, 8'h33, 8'h22, 8'h11};
    i_req_valid = 4'b1111;
    push_exp(2, 5);
    for (int k = 0; k < 5 && !stop_run; k++) begin
      wait_ready(idx);
      i_req_valid[idx] = 1'b0;
      if (k < 4) begin
        i_req_valid[idx] = 1'b1;
        push_exp(2, 5);
      end else begin
        i_req_valid = '0;
      end
    end
    wait_idle();

    // Lock on requester 2, released part-way through
    i_req_lock = 4'b0100;
    i_req_valid = 4'b0111;
    push_exp(3, 4);
    for (int k = 0; k < 5 && !stop_run; k++) begin
      wait_ready(idx);
      i_req_valid[idx] = 1'b0;
      if (k < 4) begin
        i_req_valid[idx] = 1'b1;
        if (k == 2) i_req_lock = '0;
        push_exp(3, 4);
      end else begin
        i_req_valid = '0;
      end
    end
    i_req_lock = '0;
    wait_idle();

    // Core never raises BUSY: abort from LAUNCH
    i_req_data[15:8] = 8'h5A;
    i_req_valid = 4'b0010;
    push_exp(0, 0);
    wait_ready(idx);
    i_req_valid = '0;
    wait_idle();

    // BUSY stuck high: abort from WAIT_DONE
    i_req_data[31:24] = 8'hC3;
    i_req_valid = 4'b1000;
    push_exp(3, 100);
    wait_ready(idx);
    i_req_valid = '0;
    wait_idle();

    // BUSY rises exactly on the expiry cycle
    i_req_data[7:0] = 8'h3C;
    i_req_valid = 4'b0001;
    push_exp(TO_CYC, 10);
    wait_ready(idx);
    i_req_valid = '0;
    wait_idle();

    // Reset in the middle of WAIT_DONE
    i_req_data[23:16] = 8'h96;
    i_req_valid = 4'b0100;
    push_exp(5, 60);
    wait_ready(idx);
    i_req_valid = '0;
    repeat (10) @(negedge CLK);
    RESETN = 1'b0;
    @(negedge CLK);
    check("midrst_start", 32'(o_tx_start), 32'd0);
    check("midrst_active", 32'(o_active), 32'd0);
    check("midrst_ready", 32'(o_req_ready), 32'd0);
    for (int n = 0; n < 200 && i_tx_busy; n++) @(negedge CLK);
    mptr = 0;
    RESETN = 1'b1;
    i_req_data[23:16] = 8'h69;
    i_req_valid = 4'b0100;
    push_exp(4, 6);
    wait_ready(idx);
    i_req_valid = '0;
    wait_idle();

    // Randomized traffic
    if (!stop_run) begin
      do add_random(); while (i_req_valid == '0);
      i_req_lock = 4'($urandom) & 4'($urandom);
      push_random();
      for (int it = 0; it < 40 && !stop_run; it++) begin
        wait_ready(idx);
        if (stop_run) break;
        i_req_valid[idx] = 1'b0;
        if ($urandom_range(0, 7) == 0) begin
          j = int'($urandom_range(0, NUM_REQ - 1));
          i_req_valid[j] = 1'b0;
        end
        if (it == 39) begin
          i_req_valid = '0;
          break;
        end
        if (i_req_valid == '0 && $urandom_range(0, 3) == 0) begin
          wait_idle();
          repeat ($urandom_range(1, 5)) @(negedge CLK);
        end
        do add_random(); while (i_req_valid == '0);
        i_req_lock = 4'($urandom) & 4'($urandom);
        push_random();
      end
      wait_idle();
    end

    repeat (5) @(negedge CLK);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    check("tx_model_empty", 32'(beh_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
